// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst controller.
package dma_pkg;

  localparam int unsigned AXI_4KB = 4096;
  localparam int unsigned BEATS_W = 9;

  typedef logic [7:0] axi_len_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_HS,
    DRAIN,
    FIN
  } dma_state_e;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: min of remaining beats, MAX_BEATS and the beats left before
// the next 4KB page on either the source or the destination side.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic [ADDR_W-1:0]  src,
  input  logic [ADDR_W-1:0]  dst,
  input  logic [LEN_W-1:0]   rem_beats,
  output logic [BEATS_W-1:0] beats
);

  localparam int unsigned LSB = $clog2(DATA_BYTES);
  localparam int unsigned CW  = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  logic [CW-1:0] src_room;
  logic [CW-1:0] dst_room;
  logic [CW-1:0] cand;

  always_comb begin
    src_room = CW'((ADDR_W'(AXI_4KB) - (src & ADDR_W'(AXI_4KB - 1))) >> LSB);
    dst_room = CW'((ADDR_W'(AXI_4KB) - (dst & ADDR_W'(AXI_4KB - 1))) >> LSB);
    cand     = CW'(MAX_BEATS);
    if (src_room < cand) cand = src_room;
    if (dst_room < cand) cand = dst_room;
    if (CW'(rem_beats) < cand) cand = CW'(rem_beats);
    beats = BEATS_W'(cand);
  end

endmodule

// File: rtl/dma_burst_ctrl.sv
// DMA channel controller: splits one descriptor into paired AXI INCR read/write
// burst commands, bounds in-flight writes and reports done/err.
module dma_burst_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned LEN_W           = 32,
  parameter int unsigned DATA_BYTES      = 4,
  parameter int unsigned MAX_BEATS       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              start,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              rd_cmd_valid,
  input  logic              rd_cmd_ready,
  output logic [ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]        rd_cmd_len,
  output logic              wr_cmd_valid,
  input  logic              wr_cmd_ready,
  output logic [ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]        wr_cmd_len,
  input  logic              wr_resp_valid,
  input  logic              wr_resp_err
);

  localparam int unsigned LSB   = $clog2(DATA_BYTES);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  dma_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [BEATS_W-1:0]  beats_q, beats_d, calc_beats;
  axi_len_t            len_q, len_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic                rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic                done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic                flag_q, flag_d;
  logic                rd_acc, wr_acc, pair_acc, resp_dec;
  logic [ADDR_W-1:0]   burst_bytes;

  dma_burst_calc #(
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W),
    .DATA_BYTES(DATA_BYTES),
    .MAX_BEATS (MAX_BEATS)
  ) u_calc (
    .src      (src_q),
    .dst      (dst_q),
    .rem_beats(rem_q),
    .beats    (calc_beats)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    len_d      = len_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    flag_d     = flag_q;
    pair_acc   = 1'b0;
    rd_acc     = ~rd_valid_q | rd_cmd_ready;
    wr_acc     = ~wr_valid_q | wr_cmd_ready;
    resp_dec   = wr_resp_valid && (out_q != '0);
    burst_bytes = ADDR_W'(beats_q) << LSB;

    // A stray response (nothing in flight) or a bad BRESP poisons the transfer.
    if (wr_resp_valid && ((out_q == '0) || wr_resp_err)) flag_d = 1'b1;

    case (state_q)
      IDLE: begin
        flag_d = 1'b0;
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = length;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (((src_q & ADDR_W'(DATA_BYTES - 1)) != '0) ||
            ((dst_q & ADDR_W'(DATA_BYTES - 1)) != '0) ||
            ((rem_q & LEN_W'(DATA_BYTES - 1)) != '0)) begin
          flag_d  = 1'b1;
          state_d = FIN;
        end else if (rem_q == '0) begin
          state_d = FIN;
        end else begin
          rem_d   = rem_q >> LSB;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (out_q < OUT_W'(MAX_OUTSTANDING)) begin
          beats_d    = calc_beats;
          rd_addr_d  = src_q;
          wr_addr_d  = dst_q;
          len_d      = axi_len_t'(calc_beats - BEATS_W'(1));
          rd_valid_d = 1'b1;
          wr_valid_d = 1'b1;
          state_d    = WAIT_HS;
        end
      end
      WAIT_HS: begin
        rd_valid_d = rd_valid_q & ~rd_cmd_ready;
        wr_valid_d = wr_valid_q & ~wr_cmd_ready;
        if (rd_acc && wr_acc) begin
          pair_acc = 1'b1;
          src_d    = src_q + burst_bytes;
          dst_d    = dst_q + burst_bytes;
          rem_d    = rem_q - LEN_W'(beats_q);
          state_d  = (rem_d == '0) ? DRAIN : ISSUE;
        end
      end
      DRAIN: begin
        if (out_q == '0) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_d  = out_q + OUT_W'(pair_acc) - OUT_W'(resp_dec);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    err_d  = done_d & flag_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      len_q      <= '0;
      out_q      <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      len_q      <= len_d;
      out_q      <= out_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      flag_q     <= flag_d;
    end
  end

  assign done         = done_q;
  assign err          = err_q;
  assign busy         = busy_q;
  assign rd_cmd_valid = rd_valid_q;
  assign rd_cmd_addr  = rd_addr_q;
  assign rd_cmd_len   = len_q;
  assign wr_cmd_valid = wr_valid_q;
  assign wr_cmd_addr  = wr_addr_q;
  assign wr_cmd_len   = len_q;

endmodule
